gc_stream_packer: RTL and testbench

- Synthesizable successor to the garbler output-capture path: consumes the GarbledCircuit tagged dual-lane output stream (tag_t1, cid, index0_t1/index1_t1, data0_t1/data1_t1).
- Computes the linear destination address of every record.
- Buffers records in a 2-write/1-read FIFO and emits one record per cycle on a valid/ready stream toward host DMA or an off-chip link.
- Generalised in label width, index width, FIFO depth and run-time circuit shape; adds backpressure, overflow detection and end-of-run drain, none of which the capture bench has.

---
 rtl/gc_pack_pkg.sv | 44 ++++
 rtl/gc_fifo_2w1r.sv | 76 +++++++
 rtl/gc_stream_packer.sv | 250 +++++++++++++++++++++++++
 tb/tb_gc_stream_packer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pack_pkg.sv
// ---------------------------------------------------------------------------
// gc_pack_pkg
// Shared types and constants for the garbler output stream packer.
//   rec_type_e   : record type carried on out_type (LABEL/KEY/TABLE/MASK)
//   pack_state_e : packer run-control states
//   TAG_*        : garbler tag encodings for non-label records
//   gc_rec_t     : default-width FIFO record {rtype, addr, data}
//   STALL_MARGIN : free-entry threshold at which stall is raised
// ---------------------------------------------------------------------------
package gc_pack_pkg;

    typedef enum logic [1:0] {
        LABEL = 2'd0,
        KEY   = 2'd1,
        TABLE = 2'd2,
        MASK  = 2'd3
    } rec_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_e;

    localparam logic [2:0] TAG_KEY   = 3'b001;
    localparam logic [2:0] TAG_TABLE = 3'b010;
    localparam logic [2:0] TAG_MASK  = 3'b011;

    // Two records can already be in the address stage when stall is seen,
    // and the garbler needs one more cycle to react.
    localparam int STALL_MARGIN = 4;

    localparam int GC_K  = 128;
    localparam int GC_S  = 10;
    localparam int GC_AW = 2 * GC_S + 1;

    typedef struct packed {
        rec_type_e          rtype;
        logic [GC_AW-1:0]   addr;
        logic [GC_K-1:0]    data;
    } gc_rec_t;

endpackage

// File: rtl/gc_fifo_2w1r.sv
// ---------------------------------------------------------------------------
// gc_fifo_2w1r
// Two-write / one-read record FIFO. Lane0 is always placed before lane1.
// When space runs out lane0 takes priority; anything that cannot be stored
// is dropped and flagged on drop for that cycle.
// Ports:
//   clk, rst           clock, synchronous active-high reset (pointers/count)
//   wr0_en/wr0_rec     lane0 write request and record
//   wr1_en/wr1_rec     lane1 write request and record
//   rd_en              pop the head record (ignored when empty)
//   rd_rec             head record, stable until popped
//   empty              no records stored
//   count, free        stored and free entries, before this cycle's update
//   drop               at least one requested lane was not stored
// ---------------------------------------------------------------------------
module gc_fifo_2w1r
    import gc_pack_pkg::*;
#(
    parameter int  DEPTH = 64,
    parameter type rec_t = gc_rec_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_en,
    input  rec_t          wr0_rec,
    input  logic          wr1_en,
    input  rec_t          wr1_rec,
    input  logic          rd_en,
    output rec_t          rd_rec,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free,
    output logic          drop
);

    rec_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          acc0, acc1, rd_fire;
    logic [CW-1:0] n_wr;
    logic [PW-1:0] wptr1;

    assign count   = cnt_q;
    assign free    = CW'(DEPTH) - cnt_q;
    assign empty   = (cnt_q == '0);
    assign rd_fire = rd_en && !empty;

    // Space is judged on the count before this cycle's read.
    assign acc0  = wr0_en && (free != '0);
    assign acc1  = wr1_en && (free > (acc0 ? CW'(1) : CW'(0)));
    assign drop  = (wr0_en && !acc0) || (wr1_en && !acc1);
    assign n_wr  = CW'(acc0) + CW'(acc1);
    assign wptr1 = wptr_q + PW'(acc0);

    assign rd_rec = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + PW'(n_wr);
            rptr_q <= rptr_q + PW'(rd_fire);
            cnt_q  <= cnt_q + n_wr - CW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) mem_q[wptr_q] <= wr0_rec;
        if (acc1) mem_q[wptr1]  <= wr1_rec;
    end

endmodule

// File: rtl/gc_stream_packer.sv
// ---------------------------------------------------------------------------
// gc_stream_packer
// Captures the garbler's tagged dual-lane output stream, computes a linear
// destination address per record, buffers records in a 2W/1R FIFO and emits
// one record per cycle on a valid/ready stream.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start                             begin a run (from IDLE or DONE)
//   cfg_in_size/cfg_and_size/cfg_cc   run-time circuit shape
//   tag_t1, cid, index*_t1, data*_t1  garbler record stream
//   stall                             registered hold request to garbler
//   out_valid/out_ready               output handshake
//   out_type/out_addr/out_data        output record
//   overflow                          sticky record-loss flag
//   done                              run finished and FIFO drained
// Optional: define GC_PACK_STATS_EN to add stat_count, per-type saturating
// counters of records accepted into the FIFO.
// ---------------------------------------------------------------------------
module gc_stream_packer
    import gc_pack_pkg::*;
#(
    parameter int K     = 128,
    parameter int S     = 10,
    parameter int DEPTH = 64,
    parameter int AW    = 2 * S + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [S-1:0]  cfg_in_size,
    input  logic [S-1:0]  cfg_and_size,
    input  logic [S-1:0]  cfg_cc,
    input  logic [2:0]    tag_t1,
    input  logic [S-1:0]  cid,
    input  logic [S-1:0]  index0_t1,
    input  logic [S-1:0]  index1_t1,
    input  logic [K-1:0]  data0_t1,
    input  logic [K-1:0]  data1_t1,
    output logic          stall,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_type,
    output logic [AW-1:0] out_addr,
    output logic [K-1:0]  out_data,
    output logic          overflow,
    output logic          done
`ifdef GC_PACK_STATS_EN
    ,
    output logic [AW-1:0] stat_count [4]
`endif
);

    localparam int W2 = 2 * S + 2;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        rec_type_e     rtype;
        logic [AW-1:0] addr;
        logic [K-1:0]  data;
    } rec_t;

    pack_state_e   state_q, state_d;
    logic          start_clr;
    logic          stall_q, ovf_q;

    logic          cap;
    logic [W2-1:0] label_base, table_base;
    logic          v0_d, v1_d;
    rec_type_e     type_d;
    logic [AW-1:0] a0_d, a1_d;

    logic          v0_p0, v1_p0;
    rec_type_e     type_p0;
    logic [AW-1:0] addr0_p0, addr1_p0;
    logic [K-1:0]  data0_p0, data1_p0;

    rec_t          wr0_rec, wr1_rec, rd_rec;
    logic          fifo_empty, fifo_drop, rd_en, drained;
    logic [CW-1:0] fifo_cnt, fifo_free;

    // The cycle on which cid reaches cfg_cc ends the run; its tag is dropped.
    assign cap        = (state_q == ST_RUN) && (cid != cfg_cc);
    assign label_base = W2'(cid) * W2'(cfg_in_size);
    assign table_base = W2'(2) * W2'(cid) * W2'(cfg_and_size);

    always_comb begin
        v0_d   = 1'b0;
        v1_d   = 1'b0;
        type_d = LABEL;
        a0_d   = '0;
        a1_d   = '0;
        if (cap) begin
            if (tag_t1[2]) begin
                v0_d   = tag_t1[0];
                v1_d   = tag_t1[1];
                type_d = LABEL;
                a0_d   = AW'(label_base + W2'(index0_t1));
                a1_d   = AW'(label_base + W2'(index1_t1));
            end else begin
                case (tag_t1)
                    TAG_KEY: begin
                        v0_d   = 1'b1;
                        v1_d   = 1'b1;
                        type_d = KEY;
                        a0_d   = AW'(0);
                        a1_d   = AW'(1);
                    end
                    TAG_TABLE: begin
                        v0_d   = 1'b1;
                        v1_d   = 1'b1;
                        type_d = TABLE;
                        a0_d   = AW'(table_base + W2'(index0_t1));
                        a1_d   = AW'(table_base + W2'(index1_t1));
                    end
                    TAG_MASK: begin
                        v0_d   = 1'b1;
                        type_d = MASK;
                        a0_d   = AW'(cid);
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---- stage p0: address computed, record waiting for FIFO write ----
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_p0 <= 1'b0;
            v1_p0 <= 1'b0;
        end else begin
            v0_p0 <= v0_d;
            v1_p0 <= v1_d;
        end
    end

    always_ff @(posedge clk) begin
        type_p0  <= type_d;
        addr0_p0 <= a0_d;
        addr1_p0 <= a1_d;
        data0_p0 <= data0_t1;
        data1_p0 <= data1_t1;
    end

    assign wr0_rec = '{rtype: type_p0, addr: addr0_p0, data: data0_p0};
    assign wr1_rec = '{rtype: type_p0, addr: addr1_p0, data: data1_p0};

    // ---- stage p1: FIFO storage and output ----
    gc_fifo_2w1r #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr0_en  (v0_p0),
        .wr0_rec (wr0_rec),
        .wr1_en  (v1_p0),
        .wr1_rec (wr1_rec),
        .rd_en   (rd_en),
        .rd_rec  (rd_rec),
        .empty   (fifo_empty),
        .count   (fifo_cnt),
        .free    (fifo_free),
        .drop    (fifo_drop)
    );

    assign out_valid = !fifo_empty;
    assign rd_en     = out_valid && out_ready;
    assign out_type  = rd_rec.rtype;
    assign out_addr  = rd_rec.addr;
    assign out_data  = rd_rec.data;

    // Drained once nothing is in the address stage and the FIFO is empty
    // after this cycle's pop, so done follows the last handshake directly.
    assign drained = !(v0_p0 || v1_p0) &&
                     ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && rd_en));

    always_comb begin
        state_d   = state_q;
        start_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    start_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (cid == cfg_cc) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drained) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    start_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= (fifo_free <= CW'(STALL_MARGIN));
            if (start_clr)      ovf_q <= 1'b0;
            else if (fifo_drop) ovf_q <= 1'b1;
        end
    end

    assign stall    = stall_q;
    assign overflow = ovf_q;
    assign done     = (state_q == ST_DONE);

`ifdef GC_PACK_STATS_EN
    logic [1:0]    n_lanes, n_acc;
    logic [AW-1:0] stat_q [4];

    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a,
                                              input logic [1:0]    n);
        logic [AW:0] s;
        s = {1'b0, a} + (AW+1)'(n);
        return s[AW] ? '1 : s[AW-1:0];
    endfunction

    // A drop with one free entry means lane0 landed; with none, nothing did.
    always_comb begin
        n_lanes = {1'b0, v0_p0} + {1'b0, v1_p0};
        n_acc   = n_lanes;
        if (fifo_drop) n_acc = (fifo_free == '0) ? 2'd0 : 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || start_clr) begin
            for (int i = 0; i < 4; i++) stat_q[i] <= '0;
        end else if ((state_q != ST_DONE) && (n_acc != 2'd0)) begin
            stat_q[type_p0] <= sat_add(stat_q[type_p0], n_acc);
        end
    end

    assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_gc_stream_packer.sv
module tb_gc_stream_packer;

    localparam int K     = 32;
    localparam int S     = 10;
    localparam int DEPTH = 8;
    localparam int AW    = 2 * S + 1;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic [S-1:0]  cfg_in_size, cfg_and_size, cfg_cc, cid, idx0, idx1;
    logic [2:0]    tag;
    logic [K-1:0]  d0, d1;
    logic          stall, out_valid, overflow, done;
    logic [1:0]    out_type;
    logic [AW-1:0] out_addr;
    logic [K-1:0]  out_data;
`ifdef GC_PACK_STATS_EN
    logic [AW-1:0] stat_count [4];
`endif

    int total = 0;
    int bad   = 0;

    logic [1+2+AW+K-1:0] got_v, exp_v;

    gc_stream_packer #(.K(K), .S(S), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_in_size  (cfg_in_size),
        .cfg_and_size (cfg_and_size),
        .cfg_cc       (cfg_cc),
        .tag_t1       (tag),
        .cid          (cid),
        .index0_t1    (idx0),
        .index1_t1    (idx1),
        .data0_t1     (d0),
        .data1_t1     (d1),
        .stall        (stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_type     (out_type),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .overflow     (overflow),
        .done         (done)
`ifdef GC_PACK_STATS_EN
        ,
        .stat_count   (stat_count)
`endif
    );

    always #5 clk = ~clk;

    assign got_v = {out_valid, out_type, out_addr, out_data};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; tag = 3'b000;
        cid = '0; idx0 = '0; idx1 = '0; d0 = '0; d1 = '0;
        cfg_in_size = 10'd4; cfg_and_size = 10'd5; cfg_cc = 10'd2;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({out_valid, stall, overflow, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got v/s/o/d=%b exp=0000",
                     {out_valid, stall, overflow, done});
        end
        // Idle: tags must be ignored
        out_ready = 1'b1; cid = 10'd1; tag = 3'b111;
        tick(); tag = 3'b000; tick(); tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignore out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_label();
        cfg_in_size = 10'd4; cfg_cc = 10'd2; cid = 10'd0; out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        cid = 10'd1; tag = 3'b111; idx0 = 10'd2; idx1 = 10'd3;
        d0 = 32'h0000_00A0; d1 = 32'h0000_00A1;
        tick();
        tag = 3'b000;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL label_latency1 out_valid got=%b exp=0", out_valid);
        end
        tick();
        exp_v = {1'b1, 2'd0, 21'd6, 32'h0000_00A0};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL label_lane0 got=%h exp=%h", got_v, exp_v);
        end
        tick();
        exp_v = {1'b1, 2'd0, 21'd7, 32'h0000_00A1};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL label_lane1 got=%h exp=%h", got_v, exp_v);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL label_empty out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_table();
        cfg_cc = 10'd7; cfg_and_size = 10'd5;
        cid = 10'd2; tag = 3'b010; idx0 = 10'd0; idx1 = 10'd1;
        d0 = 32'h0000_00B0; d1 = 32'h0000_00B1;
        tick(); tag = 3'b000; tick();
        exp_v = {1'b1, 2'd2, 21'd20, 32'h0000_00B0};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL table_lane0 got=%h exp=%h", got_v, exp_v);
        end
        tick();
        exp_v = {1'b1, 2'd2, 21'd21, 32'h0000_00B1};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL table_lane1 got=%h exp=%h", got_v, exp_v);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL table_empty out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_key_mask();
        cid = 10'd1; tag = 3'b001; idx0 = 10'd5; idx1 = 10'd6;
        d0 = 32'h0000_1111; d1 = 32'h0000_2222;
        tick();
        tag = 3'b011; idx0 = 10'd9; d0 = 32'h0000_3333; d1 = 32'h0000_4444;
        tick();
        tag = 3'b000;
        exp_v = {1'b1, 2'd1, 21'd0, 32'h0000_1111};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL key_lane0 got=%h exp=%h", got_v, exp_v);
        end
        tick();
        exp_v = {1'b1, 2'd1, 21'd1, 32'h0000_2222};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL key_lane1 got=%h exp=%h", got_v, exp_v);
        end
        tick();
        exp_v = {1'b1, 2'd3, 21'd1, 32'h0000_3333};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL mask_rec got=%h exp=%h", got_v, exp_v);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mask_lane1_ignored out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [1:0]    et;
        logic [AW-1:0] ea;
        logic [K-1:0]  ed;
        out_ready = 1'b0; cid = 10'd1; idx0 = 10'd3; idx1 = 10'd1;
        for (int i = 0; i < 6; i++) begin
            tag = (i == 3) ? 3'b101 : 3'b010;
            d0 = 32'h100 + 32'(i);
            d1 = 32'h200 + 32'(i);
            tick();
            if (i == 2) begin
                total++;
                if (stall !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_low_at2 got=%b exp=0", stall);
                end
            end
            if (i == 3) begin
                total++;
                if (stall !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_high_at4 got=%b exp=1", stall);
                end
            end
            if (i == 4) begin
                total++;
                if (overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_low_at7 got=%b exp=0", overflow);
                end
            end
            if (i == 5) begin
                total++;
                if (overflow !== 1'b1) begin
                    bad++;
                    $display("FAIL ovf_set got=%b exp=1", overflow);
                end
            end
        end
        tag = 3'b000;
        tick();
        total++;
        if ({overflow, stall} !== 2'b11) begin
            bad++;
            $display("FAIL ovf_sticky ovf/stall got=%b exp=11", {overflow, stall});
        end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j < 6) begin
                et = 2'd2;
                ea = (j % 2 == 0) ? 21'd13 : 21'd11;
                ed = ((j % 2 == 0) ? 32'h100 : 32'h200) + 32'(j / 2);
            end else if (j == 6) begin
                et = 2'd0; ea = 21'd7; ed = 32'h103;
            end else begin
                et = 2'd2; ea = 21'd13; ed = 32'h104;
            end
            exp_v = {1'b1, et, ea, ed};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL ovf_drain[%0d] got=%h exp=%h", j, got_v, exp_v);
            end
            tick();
        end
        total++;
        if ({out_valid, overflow} !== 2'b01) begin
            bad++;
            $display("FAIL ovf_after_drain valid/ovf got=%b exp=01",
                     {out_valid, overflow});
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b0; cfg_cc = 10'd2; cfg_and_size = 10'd5;
        cid = 10'd1; tag = 3'b010; idx0 = 10'd0; idx1 = 10'd1;
        d0 = 32'h0000_00C0; d1 = 32'h0000_00C1;
        tick();
        tag = 3'b011; d0 = 32'h0000_00C2;
        tick();
        cid = 10'd2; tag = 3'b010; d0 = 32'h0000_00DD; d1 = 32'h0000_00EE;
        tick();
        tag = 3'b000;
        total++;
        if ({done, out_valid} !== 2'b01) begin
            bad++;
            $display("FAIL drain_start done/valid got=%b exp=01", {done, out_valid});
        end
        for (int k = 0; k < 5; k++) begin
            out_ready = (k % 2 == 0);
            if (k % 2 == 0) begin
                case (k)
                    0:       exp_v = {1'b1, 2'd2, 21'd10, 32'h0000_00C0};
                    2:       exp_v = {1'b1, 2'd2, 21'd11, 32'h0000_00C1};
                    default: exp_v = {1'b1, 2'd3, 21'd1,  32'h0000_00C2};
                endcase
                total++;
                if (got_v !== exp_v) begin
                    bad++;
                    $display("FAIL drain_rec[%0d] got=%h exp=%h", k, got_v, exp_v);
                end
            end
            tick();
            if (k == 3) begin
                total++;
                if ({done, out_valid} !== 2'b01) begin
                    bad++;
                    $display("FAIL drain_last_pending done/valid got=%b exp=01",
                             {done, out_valid});
                end
            end
        end
        total++;
        if ({done, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL drain_done done/valid got=%b exp=10", {done, out_valid});
        end
        cid = 10'd1; tag = 3'b010; out_ready = 1'b1;
        tick(); tick(); tick();
        tag = 3'b000;
        total++;
        if ({done, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL done_ignore done/valid got=%b exp=10", {done, out_valid});
        end
        cid = 10'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({done, overflow} !== 2'b00) begin
            bad++;
            $display("FAIL start_clears done/ovf got=%b exp=00", {done, overflow});
        end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0; cfg_cc = 10'd7; cid = 10'd1; idx0 = 10'd3; idx1 = 10'd1;
        d0 = 32'h0000_0011; d1 = 32'h0000_0022;
        tag = 3'b010; tick();
        tag = 3'b010; tick();
        tag = 3'b101; tick();
        tag = 3'b000; tick();
        total++;
        if ({stall, out_valid} !== 2'b11) begin
            bad++;
            $display("FAIL rst_pre stall/valid got=%b exp=11", {stall, out_valid});
        end
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if ({out_valid, stall, overflow, done} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid v/s/o/d got=%b exp=0000",
                     {out_valid, stall, overflow, done});
        end
        out_ready = 1'b1; tag = 3'b010;
        tick(); tick(); tick();
        tag = 3'b000;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle_ignore out_valid got=%b exp=0", out_valid);
        end
        start = 1'b1; tick(); start = 1'b0;
        tag = 3'b010; d0 = 32'h0000_0055; tick();
        tag = 3'b000; tick();
        exp_v = {1'b1, 2'd2, 21'd13, 32'h0000_0055};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL rst_restart got=%h exp=%h", got_v, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_label();
        test_table();
        test_key_mask();
        test_overflow();
        test_drain();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
